// File: rtl/fix_field_tokenizer.sv
// fix_field_tokenizer: front-end of the FIX parser.
// Splits the raw byte stream into <tag>=<value><SOH> fields, decodes the ASCII
// tag into a binary number and streams value bytes with a last-beat marker.
// A one-byte hold register gives the lookahead needed to mark the last beat.
// Malformed fields raise err_o and the parser resynchronises on the next SOH.
// Optional feature: define FIX_CHECKSUM_EN to compute the FIX body checksum
// (sum mod 256), reported alongside tag 10.
module fix_field_tokenizer #(
  parameter int TAG_W          = 16,
  parameter int MAX_TAG_DIGITS = 5,
  parameter int VAL_MAX        = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             tag_valid_o,
  output logic [7:0]       val_data_o,
  output logic             val_valid_o,
  output logic             val_last_o,
  input  logic             val_ready_i,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [7:0]       cksum_o,
  output logic             cksum_valid_o
);

  localparam int DCNT_W = $clog2(MAX_TAG_DIGITS + 1);
  localparam int VCNT_W = $clog2(VAL_MAX + 1);

  localparam logic [7:0] CH_SOH = 8'h01;
  localparam logic [7:0] CH_EQ  = 8'h3D;

  localparam logic [1:0] E_CHAR = 2'd1;
  localparam logic [1:0] E_LONG = 2'd2;
  localparam logic [1:0] E_LEN  = 2'd3;

  typedef enum logic [1:0] {S_TAG, S_VALUE, S_SKIP} state_e;

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    acc_q, acc_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
  logic [7:0]          hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [TAG_W-1:0]    tag_q;
  logic                tag_vld_q;
  logic                err_q;
  logic [7:0]          slot_data_q;
  logic                slot_vld_q;
  logic                slot_last_q;

  logic accept;
  logic is_digit, is_soh, is_eq;
  logic tag_fire, err_fire, load_slot, load_last;

  // Only the VALUE state can be blocked, and only by a full, unconsumed slot.
  // Held low while in reset so every output reads 0 until release.
  assign ready_o = rst & ((state_q != S_VALUE) | ~slot_vld_q | val_ready_i);
  assign accept  = valid_i & ready_o;

  assign is_digit = (data_i >= 8'h30) && (data_i <= 8'h39);
  assign is_soh   = (data_i == CH_SOH);
  assign is_eq    = (data_i == CH_EQ);

  // Next-state decode of the field parser for the byte being accepted.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    dcnt_d     = dcnt_q;
    vcnt_d     = vcnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    err_code_d = err_code_q;
    tag_fire   = 1'b0;
    err_fire   = 1'b0;
    load_slot  = 1'b0;
    load_last  = 1'b0;
    if (accept) begin
      unique case (state_q)
        S_TAG: begin
          if (is_digit) begin
            if (dcnt_q == DCNT_W'(MAX_TAG_DIGITS)) begin
              err_fire   = 1'b1;
              err_code_d = E_LONG;
              state_d    = S_SKIP;
            end else begin
              // ASCII digits carry their value in the low nibble.
              acc_d  = acc_q * TAG_W'(10) + TAG_W'(data_i[3:0]);
              dcnt_d = dcnt_q + DCNT_W'(1);
            end
          end else if (is_eq && (dcnt_q != '0)) begin
            tag_fire   = 1'b1;
            state_d    = S_VALUE;
            acc_d      = '0;
            dcnt_d     = '0;
            vcnt_d     = '0;
            hold_vld_d = 1'b0;
          end else if (is_soh) begin
            // Bare SOH is an empty field; digits then SOH lacks the '='.
            if (dcnt_q != '0) begin
              err_fire   = 1'b1;
              err_code_d = E_CHAR;
            end
          end else begin
            err_fire   = 1'b1;
            err_code_d = E_CHAR;
            state_d    = S_SKIP;
          end
        end
        S_VALUE: begin
          if (!is_soh) begin
            if (vcnt_q == VCNT_W'(VAL_MAX)) begin
              err_fire   = 1'b1;
              err_code_d = E_LEN;
              state_d    = S_SKIP;
            end else begin
              load_slot  = hold_vld_q;
              hold_d     = data_i;
              hold_vld_d = 1'b1;
              vcnt_d     = vcnt_q + VCNT_W'(1);
            end
          end else begin
            if (hold_vld_q) begin
              load_slot = 1'b1;
              load_last = 1'b1;
            end else begin
              err_fire   = 1'b1;
              err_code_d = E_LEN;
            end
            state_d    = S_TAG;
            vcnt_d     = '0;
            hold_vld_d = 1'b0;
          end
        end
        S_SKIP: begin
          if (is_soh) begin
            state_d = S_TAG;
            acc_d   = '0;
            dcnt_d  = '0;
          end
        end
        default: state_d = S_TAG;
      endcase
      // Any error abandons the field's partial state.
      if (err_fire) begin
        acc_d      = '0;
        dcnt_d     = '0;
        vcnt_d     = '0;
        hold_vld_d = 1'b0;
      end
    end
  end

  // Parser state, tag/error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_TAG;
      acc_q      <= '0;
      dcnt_q     <= '0;
      vcnt_q     <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      err_code_q <= '0;
      err_q      <= 1'b0;
      tag_q      <= '0;
      tag_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      dcnt_q     <= dcnt_d;
      vcnt_q     <= vcnt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      err_code_q <= err_code_d;
      err_q      <= err_fire;
      tag_vld_q  <= tag_fire;
      if (tag_fire) tag_q <= acc_q;
    end
  end

  // Output slot: loaded from hold, held until downstream takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_data_q <= '0;
      slot_vld_q  <= 1'b0;
      slot_last_q <= 1'b0;
    end else if (load_slot) begin
      slot_data_q <= hold_q;
      slot_last_q <= load_last;
      slot_vld_q  <= 1'b1;
    end else if (val_ready_i) begin
      slot_vld_q  <= 1'b0;
    end
  end

  assign tag_o       = tag_q;
  assign tag_valid_o = tag_vld_q;
  assign val_data_o  = slot_data_q;
  assign val_valid_o = slot_vld_q;
  assign val_last_o  = slot_last_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

`ifdef FIX_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] ck_q;
  logic       ck_vld_q;
  logic       t10_q;
  logic       is_t10;

  assign is_t10 = (acc_q == TAG_W'(10));

  // Running body sum; snapshot at tag 10, restart when its field closes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q    <= '0;
      ck_q     <= '0;
      ck_vld_q <= 1'b0;
      t10_q    <= 1'b0;
    end else begin
      ck_vld_q <= 1'b0;
      if (accept) begin
        if (t10_q && (err_fire || ((state_q == S_VALUE) && is_soh))) begin
          sum_q <= '0;
          t10_q <= 1'b0;
        end else begin
          sum_q <= sum_q + data_i;
        end
        // 8'h9E backs out the "10=" just summed.
        if (tag_fire && is_t10) begin
          ck_q     <= sum_q + data_i - 8'h9E;
          ck_vld_q <= 1'b1;
          t10_q    <= 1'b1;
        end
      end
    end
  end

  assign cksum_o       = ck_q;
  assign cksum_valid_o = ck_vld_q;
`else
  assign cksum_o       = 8'h00;
  assign cksum_valid_o = 1'b0;
`endif

endmodule
